// File: rtl/wb_stage.sv
// Write-back stage: retires MEM-stage instructions into the GPR file, aligning/extending load data.
// Latency 1 for non-loads, dmem_ack+1 for loads; mem_rdy is low while a load waits on data memory.
module wb_stage #(
  parameter int RSZ     = 32,
  parameter int GPR_ASZ = 5,
  parameter int CNT_SZ  = 64
) (
  input  logic               clk_in,
  input  logic               reset_n_in,
  input  logic               mem_valid,
  output logic               mem_rdy,
  input  logic               mem_rd_wr,
  input  logic [GPR_ASZ-1:0] mem_rd_addr,
  input  logic [RSZ-1:0]     mem_rd_data,
  input  logic               mem_is_ld,
  input  logic [1:0]         mem_ld_size,
  input  logic               mem_ld_unsigned,
  input  logic [1:0]         mem_ld_offset,
  input  logic               dmem_ack,
  input  logic [RSZ-1:0]     dmem_rd_data,
  input  logic               dmem_err,
  input  logic               flush_in,
  output logic               gpr_Rd_wr,
  output logic [GPR_ASZ-1:0] gpr_Rd_addr,
  output logic [RSZ-1:0]     gpr_Rd_data,
  output logic               retire,
  output logic               ld_err,
  output logic [CNT_SZ-1:0]  instret
);

  typedef enum logic {IDLE, WAIT_LD} state_t;

  state_t state, state_n;

  logic               rdy_q;
  logic               ld_rd_wr;
  logic [GPR_ASZ-1:0] ld_addr;
  logic [1:0]         ld_size;
  logic [1:0]         ld_off;
  logic               ld_uns;

  logic               xfer;
  logic               wr_n, retire_n, err_n, cap_n;
  logic [GPR_ASZ-1:0] addr_n;
  logic [RSZ-1:0]     data_n;
  logic [RSZ-1:0]     shifted, ld_val;
  logic               ld_bad;

  // mem_rdy is registered so it reads 0 while reset is asserted
  assign mem_rdy = rdy_q;
  assign xfer    = mem_valid & rdy_q;

  always_comb begin
    shifted = dmem_rd_data >> {ld_off, 3'b000};
    case (ld_size)
      2'd0:    ld_val = {{(RSZ-8){~ld_uns & shifted[7]}}, shifted[7:0]};
      2'd1:    ld_val = {{(RSZ-16){~ld_uns & shifted[15]}}, shifted[15:0]};
      default: ld_val = shifted;
    endcase
    ld_bad = dmem_err
           | (ld_size == 2'd3)
           | ((ld_size == 2'd1) & (ld_off == 2'd3))
           | ((ld_size == 2'd2) & (ld_off != 2'd0));
  end

  always_comb begin
    state_n  = state;
    wr_n     = 1'b0;
    retire_n = 1'b0;
    err_n    = 1'b0;
    cap_n    = 1'b0;
    addr_n   = mem_rd_addr;
    data_n   = mem_rd_data;
    case (state)
      IDLE: begin
        if (!flush_in && xfer) begin
          if (mem_is_ld) begin
            cap_n   = 1'b1;
            state_n = WAIT_LD;
          end else begin
            wr_n     = mem_rd_wr & (mem_rd_addr != '0);
            retire_n = 1'b1;
          end
        end
      end
      WAIT_LD: begin
        if (flush_in) begin
          state_n = IDLE;
        end else if (dmem_ack) begin
          state_n = IDLE;
          addr_n  = ld_addr;
          data_n  = ld_val;
          if (ld_bad) begin
            err_n = 1'b1;
          end else begin
            wr_n     = ld_rd_wr & (ld_addr != '0);
            retire_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      rdy_q       <= 1'b0;
      gpr_Rd_wr   <= 1'b0;
      gpr_Rd_addr <= '0;
      gpr_Rd_data <= '0;
      retire      <= 1'b0;
      ld_err      <= 1'b0;
      instret     <= '0;
      ld_rd_wr    <= 1'b0;
      ld_addr     <= '0;
      ld_size     <= 2'd0;
      ld_off      <= 2'd0;
      ld_uns      <= 1'b0;
    end else begin
      rdy_q     <= (state_n == IDLE);
      gpr_Rd_wr <= wr_n;
      retire    <= retire_n;
      ld_err    <= err_n;
      instret   <= instret + CNT_SZ'(retire_n);
      // write port holds its last value between writes
      if (wr_n) begin
        gpr_Rd_addr <= addr_n;
        gpr_Rd_data <= data_n;
      end
      if (cap_n) begin
        ld_rd_wr <= mem_rd_wr;
        ld_addr  <= mem_rd_addr;
        ld_size  <= mem_ld_size;
        ld_off   <= mem_ld_offset;
        ld_uns   <= mem_ld_unsigned;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed cases plus randomized loads/non-loads vs a reference model.
module tb_wb_stage;

  logic        clk_in = 1'b0;
  logic        reset_n_in = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_rdy;
  logic        mem_rd_wr = 1'b0;
  logic [4:0]  mem_rd_addr = '0;
  logic [31:0] mem_rd_data = '0;
  logic        mem_is_ld = 1'b0;
  logic [1:0]  mem_ld_size = '0;
  logic        mem_ld_unsigned = 1'b0;
  logic [1:0]  mem_ld_offset = '0;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rd_data = '0;
  logic        dmem_err = 1'b0;
  logic        flush_in = 1'b0;
  logic        gpr_Rd_wr;
  logic [4:0]  gpr_Rd_addr;
  logic [31:0] gpr_Rd_data;
  logic        retire;
  logic        ld_err;
  logic [63:0] instret;

  wb_stage #(.RSZ(32), .GPR_ASZ(5), .CNT_SZ(64)) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .mem_valid(mem_valid), .mem_rdy(mem_rdy),
    .mem_rd_wr(mem_rd_wr), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_is_ld(mem_is_ld), .mem_ld_size(mem_ld_size), .mem_ld_unsigned(mem_ld_unsigned),
    .mem_ld_offset(mem_ld_offset),
    .dmem_ack(dmem_ack), .dmem_rd_data(dmem_rd_data), .dmem_err(dmem_err),
    .flush_in(flush_in),
    .gpr_Rd_wr(gpr_Rd_wr), .gpr_Rd_addr(gpr_Rd_addr), .gpr_Rd_data(gpr_Rd_data),
    .retire(retire), .ld_err(ld_err), .instret(instret)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic        ret;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic        mon_en = 1'b0;
  logic [63:0] exp_instret = '0;
  logic [4:0]  last_addr = '0;
  logic [31:0] last_data = '0;

  // load attributes remembered at transfer time for the reference model
  logic        m_rd_wr;
  logic [4:0]  m_addr;
  logic [1:0]  m_sz, m_off;
  logic        m_uns;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, req);
  endtask

  function automatic exp_t mk_wr(input logic rd_wr, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.ret = 1'b1; e.wr = rd_wr && (a != 0); e.addr = a; e.data = d; e.err = 1'b0;
    return e;
  endfunction

  function automatic exp_t load_model(input logic [31:0] d, input logic err);
    exp_t        e;
    logic [31:0] w, v;
    logic        legal;
    legal = !err && ((m_sz == 0) || (m_sz == 1 && m_off != 3) || (m_sz == 2 && m_off == 0));
    w = d >> (8 * m_off);
    if (m_sz == 0) begin
      v = w & 32'hFF;
      if (!m_uns && v >= 128) v = v - 256;
    end else if (m_sz == 1) begin
      v = w & 32'hFFFF;
      if (!m_uns && v >= 32768) v = v - 65536;
    end else begin
      v = w;
    end
    if (legal) e = mk_wr(m_rd_wr, m_addr, v);
    else begin
      e.ret = 1'b0; e.wr = 1'b0; e.addr = '0; e.data = '0; e.err = 1'b1;
    end
    return e;
  endfunction

  always @(posedge clk_in) cyc <= cyc + 1;

  // monitor: every output event must match the head of the scoreboard
  always @(negedge clk_in) begin
    exp_t e;
    if (mon_en && reset_n_in) begin
      if (retire || ld_err || gpr_Rd_wr) begin
        if (sbq.size() == 0) begin
          chk("unexpected_event", {61'd0, retire, ld_err, gpr_Rd_wr}, 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("retire", retire, e.ret);
          chk("ld_err", ld_err, e.err);
          chk("rd_wr", gpr_Rd_wr, e.wr);
          if (e.wr) begin
            chk("rd_addr", gpr_Rd_addr, e.addr);
            chk("rd_data", gpr_Rd_data, e.data);
            last_addr = e.addr;
            last_data = e.data;
          end
          if (e.ret) exp_instret = exp_instret + 1;
        end
      end
      chk("instret", instret, exp_instret);
      if (!gpr_Rd_wr) begin
        chk("hold_addr", gpr_Rd_addr, last_addr);
        chk("hold_data", gpr_Rd_data, last_data);
      end
    end
  end

  task automatic xfer(input logic ld, input logic rd_wr, input logic [4:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic [1:0] off, input logic uns);
    int n;
    mem_valid = 1'b1; mem_is_ld = ld; mem_rd_wr = rd_wr; mem_rd_addr = a; mem_rd_data = d;
    mem_ld_size = sz; mem_ld_offset = off; mem_ld_unsigned = uns;
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!mem_rdy && n < 50);
    if (!mem_rdy) chk("rdy_timeout", mem_rdy, 1);
    @(posedge clk_in);
    if (!ld) sbq.push_back(mk_wr(rd_wr, a, d));
    else begin
      m_rd_wr = rd_wr; m_addr = a; m_sz = sz; m_off = off; m_uns = uns;
    end
    #1;
  endtask

  task automatic ack(input int dly, input logic [31:0] d, input logic err, input logic expect_it);
    for (int k = 0; k < dly; k++) begin
      @(negedge clk_in);
      chk("rdy_low_wait", mem_rdy, 0);
      @(posedge clk_in);
      #1;
    end
    dmem_ack = 1'b1; dmem_rd_data = d; dmem_err = err;
    @(posedge clk_in);
    if (expect_it) sbq.push_back(load_model(d, err));
    #1;
    dmem_ack = 1'b0; dmem_err = 1'b0; dmem_rd_data = $urandom;
  endtask

  task automatic idle(input int n);
    mem_valid = 1'b0;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ic;
    int          c0, r;
    logic [4:0]  a;

    #1 reset_n_in = 1'b0;
    #2;
    chk("rst_rdy", mem_rdy, 0);
    chk("rst_wr", gpr_Rd_wr, 0);
    chk("rst_retire", retire, 0);
    chk("rst_instret", instret, 0);
    @(negedge clk_in); @(negedge clk_in);
    reset_n_in = 1'b1;
    mon_en = 1'b1;

    // non-load to x5, then to x0
    xfer(0, 1, 5'd5, 32'h12345678, 0, 0, 0);
    chk("t1_wr", gpr_Rd_wr, 1);
    chk("t1_addr", gpr_Rd_addr, 5);
    chk("t1_data", gpr_Rd_data, 32'h12345678);
    chk("t1_instret", instret, 1);
    xfer(0, 1, 5'd0, 32'hDEADBEEF, 0, 0, 0);
    chk("t2_wr", gpr_Rd_wr, 0);
    chk("t2_retire", retire, 1);
    chk("t2_instret", instret, 2);
    idle(1);

    // LB off 3 and LHU off 2
    xfer(1, 1, 5'd7, 32'h0, 2'd0, 2'd3, 1'b0);
    ack(1, 32'h80000000, 0, 1);
    chk("t3_lb", gpr_Rd_data, 32'hFFFFFF80);
    xfer(1, 1, 5'd8, 32'h0, 2'd1, 2'd2, 1'b1);
    ack(0, 32'hABCD0000, 0, 1);
    chk("t3_lhu", gpr_Rd_data, 32'h0000ABCD);
    idle(1);

    // late ack with mem_valid held, then back-to-back non-loads
    xfer(1, 1, 5'd9, 32'h0, 2'd2, 2'd0, 1'b0);
    fork
      begin
        ack(3, 32'hCAFEF00D, 0, 1);
        chk("t4_ld_wr", gpr_Rd_wr, 1);
      end
      xfer(0, 1, 5'd10, 32'h10, 0, 0, 0);
    join
    c0 = cyc;
    xfer(0, 1, 5'd11, 32'h11, 0, 0, 0);
    xfer(0, 1, 5'd12, 32'h12, 0, 0, 0);
    xfer(0, 1, 5'd13, 32'h13, 0, 0, 0);
    chk("t4_b2b_cycles", cyc - c0, 3);
    chk("t4_last_wr", gpr_Rd_wr, 1);
    idle(1);

    // misaligned LW and bus error
    ic = instret;
    xfer(1, 1, 5'd14, 32'h0, 2'd2, 2'd2, 1'b0);
    ack(0, 32'h55667788, 0, 1);
    chk("t5_lw_err", ld_err, 1);
    chk("t5_lw_nowr", gpr_Rd_wr, 0);
    xfer(1, 1, 5'd15, 32'h0, 2'd0, 2'd0, 1'b0);
    ack(2, 32'h000000AA, 1, 1);
    chk("t5_bus_err", ld_err, 1);
    chk("t5_instret", instret, ic);
    idle(1);

    // reset in the middle of a load wait
    xfer(1, 1, 5'd16, 32'h0, 2'd2, 2'd0, 1'b0);
    mem_valid = 1'b0;
    @(posedge clk_in); #1;
    reset_n_in = 1'b0;
    #1;
    chk("t6_rst_rdy", mem_rdy, 0);
    chk("t6_rst_addr", gpr_Rd_addr, 0);
    chk("t6_rst_data", gpr_Rd_data, 0);
    chk("t6_rst_instret", instret, 0);
    sbq.delete();
    exp_instret = '0; last_addr = '0; last_data = '0;
    @(negedge clk_in);
    reset_n_in = 1'b1;
    @(posedge clk_in); #1;
    ack(0, 32'h11111111, 0, 0);
    idle(2);
    chk("t6_post_rst_instret", instret, 0);

    // flush during load wait, then flush on the transfer cycle itself
    xfer(1, 1, 5'd17, 32'h0, 2'd2, 2'd0, 1'b0);
    mem_valid = 1'b0;
    flush_in = 1'b1;
    @(posedge clk_in); #1;
    flush_in = 1'b0;
    chk("t6_flush_rdy", mem_rdy, 1);
    ack(0, 32'h22222222, 0, 0);
    idle(1);
    mem_valid = 1'b1; mem_is_ld = 1'b0; mem_rd_wr = 1'b1; mem_rd_addr = 5'd3; mem_rd_data = 32'h33;
    flush_in = 1'b1;
    @(negedge clk_in);
    @(posedge clk_in); #1;
    chk("t6_flush_xfer_wr", gpr_Rd_wr, 0);
    chk("t6_flush_xfer_ret", retire, 0);
    mem_is_ld = 1'b1;
    @(posedge clk_in); #1;
    mem_valid = 1'b0; flush_in = 1'b0;
    @(negedge clk_in);
    chk("t6_flush_ld_rdy", mem_rdy, 1);
    idle(2);

    // randomized mix
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      if (r < 6) begin
        xfer(0, 1'($urandom), a, $urandom, 0, 0, 0);
      end else begin
        xfer(1, 1'($urandom), a, 32'h0, 2'($urandom), 2'($urandom), 1'($urandom));
        ack($urandom_range(0, 3), $urandom, ($urandom_range(0, 7) == 0), 1);
      end
      if (r == 9) idle(1);
    end
    idle(5);
    chk("sb_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
